// File: rtl/reorder_buffer_pkg.sv
// Shared widths and entry payload type for the reorder buffer.
package reorder_buffer_pkg;

   localparam int unsigned ROB_DEPTH = 16;
   localparam int unsigned ROB_TAG_W = 4;
   localparam int unsigned ROB_CNT_W = ROB_TAG_W + 1;
   localparam int unsigned PHYS_W    = 6;
   localparam int unsigned ARCH_W    = 5;

   // Static per-slot payload written at alloc; valid/done live beside it.
   typedef struct packed {
      logic              has_rd;
      logic [ARCH_W-1:0] arch_rd;
      logic [PHYS_W-1:0] phys_rd;
      logic [PHYS_W-1:0] old_phys_rd;
   } rob_payload_t;

endpackage

// File: rtl/rob_entry_array.sv
// DEPTH x entry storage: one alloc write port, one done bit-set port, one head read port.
module rob_entry_array
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en_i,
   input  logic [ROB_TAG_W-1:0] wr_tag_i,
   input  rob_payload_t         wr_data_i,
   input  logic                 done_en_i,
   input  logic [ROB_TAG_W-1:0] done_tag_i,
   input  logic                 clr_en_i,
   input  logic [ROB_TAG_W-1:0] clr_tag_i,
   input  logic [ROB_TAG_W-1:0] rd_tag_i,
   output logic                 rd_valid_o,
   output logic                 rd_done_o,
   output rob_payload_t         rd_data_o
);

   logic [ROB_DEPTH-1:0] valid_q, valid_d;
   logic [ROB_DEPTH-1:0] done_q, done_d;
   rob_payload_t         payload_q [ROB_DEPTH];

   // Flag updates: done-set, then retire clear, then alloc write (alloc wins on the same slot).
   always_comb begin
      valid_d = valid_q;
      done_d  = done_q;
      if (done_en_i && valid_q[done_tag_i]) begin
         done_d[done_tag_i] = 1'b1;
      end
      if (clr_en_i) begin
         valid_d[clr_tag_i] = 1'b0;
         done_d[clr_tag_i]  = 1'b0;
      end
      if (wr_en_i) begin
         valid_d[wr_tag_i] = 1'b1;
         done_d[wr_tag_i]  = 1'b0;
      end
   end

   // Flag registers; reset discards every in-flight entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Payload storage; contents are meaningless while the slot is invalid.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         payload_q[wr_tag_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_tag_i];
   assign rd_done_o  = done_q[rd_tag_i];
   assign rd_data_o  = payload_q[rd_tag_i];

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit buffer: out-of-order completion, one in-order retire per cycle.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_valid,
   input  logic                 alloc_has_rd,
   input  logic [ARCH_W-1:0]    alloc_arch_rd,
   input  logic [PHYS_W-1:0]    alloc_phys_rd,
   input  logic [PHYS_W-1:0]    alloc_old_phys_rd,
   output logic                 alloc_ready,
   output logic [ROB_TAG_W-1:0] alloc_tag,
   input  logic                 complete_valid,
   input  logic [ROB_TAG_W-1:0] complete_tag,
   output logic                 retire_valid,
   output logic [ROB_TAG_W-1:0] retire_tag,
   output logic [ARCH_W-1:0]    retire_arch_rd,
   output logic [PHYS_W-1:0]    retire_phys_reg,
   output logic                 retire_free_valid,
   output logic                 rob_empty,
   output logic                 rob_full
);

   logic [ROB_TAG_W-1:0] head_q, head_d;
   logic [ROB_TAG_W-1:0] tail_q, tail_d;
   logic [ROB_CNT_W-1:0] count_q, count_d;
   logic                 ret_valid_q, ret_valid_d;
   logic [ROB_TAG_W-1:0] ret_tag_q, ret_tag_d;
   logic [ARCH_W-1:0]    ret_arch_q, ret_arch_d;
   logic [PHYS_W-1:0]    ret_phys_q, ret_phys_d;
   logic                 ret_free_q, ret_free_d;
   logic                 empty_q, empty_d;
   logic                 full_q, full_d;

   logic                 alloc_fire;
   logic                 retire_fire;
   logic                 head_valid;
   logic                 head_done;
   rob_payload_t         head_data;
   rob_payload_t         alloc_data;

   assign alloc_data = '{has_rd:      alloc_has_rd,
                         arch_rd:     alloc_arch_rd,
                         phys_rd:     alloc_phys_rd,
                         old_phys_rd: alloc_old_phys_rd};

   rob_entry_array u_entries (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (alloc_fire),
      .wr_tag_i   (tail_q),
      .wr_data_i  (alloc_data),
      .done_en_i  (complete_valid),
      .done_tag_i (complete_tag),
      .clr_en_i   (retire_fire),
      .clr_tag_i  (head_q),
      .rd_tag_i   (head_q),
      .rd_valid_o (head_valid),
      .rd_done_o  (head_done),
      .rd_data_o  (head_data)
   );

   // Pointer, occupancy and retire-output next state; retire uses pre-edge done bit.
   always_comb begin
      alloc_ready = (count_q != ROB_CNT_W'(ROB_DEPTH));
      alloc_tag   = tail_q;
      alloc_fire  = alloc_valid & alloc_ready;
      retire_fire = head_valid & head_done;

      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      ret_valid_d = retire_fire;
      ret_tag_d   = ret_tag_q;
      ret_arch_d  = ret_arch_q;
      ret_phys_d  = ret_phys_q;
      ret_free_d  = 1'b0;

      if (alloc_fire) begin
         tail_d = tail_q + ROB_TAG_W'(1);
      end
      if (retire_fire) begin
         head_d     = head_q + ROB_TAG_W'(1);
         ret_tag_d  = head_q;
         ret_arch_d = head_data.arch_rd;
         ret_phys_d = head_data.old_phys_rd;
         ret_free_d = head_data.has_rd;
      end
      if (alloc_fire && !retire_fire) begin
         count_d = count_q + ROB_CNT_W'(1);
      end else if (!alloc_fire && retire_fire) begin
         count_d = count_q - ROB_CNT_W'(1);
      end

      empty_d = (count_d == '0);
      full_d  = (count_d == ROB_CNT_W'(ROB_DEPTH));
   end

   // Control and retire-output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         ret_valid_q <= 1'b0;
         ret_tag_q   <= '0;
         ret_arch_q  <= '0;
         ret_phys_q  <= '0;
         ret_free_q  <= 1'b0;
         empty_q     <= 1'b1;
         full_q      <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         ret_valid_q <= ret_valid_d;
         ret_tag_q   <= ret_tag_d;
         ret_arch_q  <= ret_arch_d;
         ret_phys_q  <= ret_phys_d;
         ret_free_q  <= ret_free_d;
         empty_q     <= empty_d;
         full_q      <= full_d;
      end
   end

   assign retire_valid      = ret_valid_q;
   assign retire_tag        = ret_tag_q;
   assign retire_arch_rd    = ret_arch_q;
   assign retire_phys_reg   = ret_phys_q;
   assign retire_free_valid = ret_free_q;
   assign rob_empty         = empty_q;
   assign rob_full          = full_q;

endmodule
